// File: rtl/mem_access_unit_if.sv
// Bundle of the EX/MEM operation, stall, data-memory port and result signals
// for mem_access_unit. "slave" is the unit's view, "master" the environment's.
interface mem_access_unit_if #(
  parameter int WIDTH = 64
);
  localparam int LANES = WIDTH / 8;

  logic             p_MEM_Valid;
  logic             p_MEM_Load;
  logic             p_MEM_Store;
  logic [1:0]       p_MEM_Size;
  logic             p_MEM_Unsigned;
  logic [WIDTH-1:0] p_MEM_Address;
  logic [WIDTH-1:0] p_MEM_StoreData;
  logic             p_MEM_Stall;
  logic             p_MEM_DataMemReq;
  logic             p_MEM_DataMemWe;
  logic [WIDTH-1:0] p_MEM_DataMemAddr;
  logic [LANES-1:0] p_MEM_DataMemByteEn;
  logic [WIDTH-1:0] p_MEM_DataMemWData;
  logic             p_MEM_DataMemWait;
  logic [WIDTH-1:0] p_MEM_DataMemRData;
  logic [WIDTH-1:0] p_MEM_LoadData;
  logic             p_MEM_LoadValid;
  logic             p_MEM_AlignErr;
  logic             p_MEM_BusErr;
  logic [1:0]       p_MEM_DbgState;

  modport slave (
    input  p_MEM_Valid, p_MEM_Load, p_MEM_Store, p_MEM_Size, p_MEM_Unsigned,
    input  p_MEM_Address, p_MEM_StoreData, p_MEM_DataMemWait, p_MEM_DataMemRData,
    output p_MEM_Stall, p_MEM_DataMemReq, p_MEM_DataMemWe, p_MEM_DataMemAddr,
    output p_MEM_DataMemByteEn, p_MEM_DataMemWData, p_MEM_LoadData,
    output p_MEM_LoadValid, p_MEM_AlignErr, p_MEM_BusErr, p_MEM_DbgState
  );

  modport master (
    output p_MEM_Valid, p_MEM_Load, p_MEM_Store, p_MEM_Size, p_MEM_Unsigned,
    output p_MEM_Address, p_MEM_StoreData, p_MEM_DataMemWait, p_MEM_DataMemRData,
    input  p_MEM_Stall, p_MEM_DataMemReq, p_MEM_DataMemWe, p_MEM_DataMemAddr,
    input  p_MEM_DataMemByteEn, p_MEM_DataMemWData, p_MEM_LoadData,
    input  p_MEM_LoadValid, p_MEM_AlignErr, p_MEM_BusErr, p_MEM_DbgState
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential MEM stage: one load/store at a time, aligned lane placement,
// stall until the memory drops Wait, extended load result and error pulses.
module mem_access_unit #(
  parameter int WIDTH    = 64,
  parameter int MAX_WAIT = 255
) (
  input logic          p_MEM_Clk,
  input logic          p_MEM_Reset,
  mem_access_unit_if.slave bus
);
  localparam int LANES = WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  // Handshake: an op is taken in IDLE when Valid & (Load | Store); Stall holds
  // the op upstream until DONE. Req stays up and stable while Wait = 1; RData
  // is sampled in the first ACCESS cycle with Wait = 0.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               req_q, req_d, we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [LANES-1:0]   be_q, be_d;
  logic               lvalid_q, lvalid_d, aerr_q, aerr_d, berr_q, berr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic               accept, illegal, misalign, timeout, ld_sign;
  logic [OFF_W-1:0]   off;
  logic [LANES-1:0]   lane_mask;
  logic [WIDTH-1:0]   data_mask, ld_shift, ld_mask, ld_ext;

  always_comb begin
    accept  = (state_q == S_IDLE) && bus.p_MEM_Valid && (bus.p_MEM_Load || bus.p_MEM_Store);
    off     = bus.p_MEM_Address[OFF_W-1:0];
    cnt_inc = cnt_q + 1'b1;
    timeout = (MAX_WAIT != 0) && (cnt_inc == CNT_W'(MAX_WAIT));
    case (bus.p_MEM_Size)
      2'd0: begin lane_mask = LANES'(1);  data_mask = WIDTH'(8'hFF);         misalign = 1'b0; end
      2'd1: begin lane_mask = LANES'(3);  data_mask = WIDTH'(16'hFFFF);      misalign = bus.p_MEM_Address[0]; end
      2'd2: begin lane_mask = LANES'(15); data_mask = WIDTH'(32'hFFFF_FFFF); misalign = |bus.p_MEM_Address[1:0]; end
      default: begin lane_mask = '1;      data_mask = '1;                    misalign = |bus.p_MEM_Address[2:0]; end
    endcase
    illegal = (bus.p_MEM_Load && bus.p_MEM_Store) || misalign ||
              ((bus.p_MEM_Size == 2'd3) && (WIDTH == 32));
  end

  // Load path works from the lane offset and size latched at accept.
  always_comb begin
    ld_shift = bus.p_MEM_DataMemRData >> {off_q, 3'b000};
    case (size_q)
      2'd0:    begin ld_mask = WIDTH'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1:    begin ld_mask = WIDTH'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2:    begin ld_mask = WIDTH'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: begin ld_mask = '1;                    ld_sign = ld_shift[WIDTH-1]; end
    endcase
    ld_ext = (uns_q || !ld_sign) ? (ld_shift & ld_mask) : (ld_shift | ~ld_mask);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    lvalid_d = 1'b0;
    aerr_d   = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && illegal) begin
          state_d = S_DONE;
          aerr_d  = 1'b1;
        end else if (accept) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = bus.p_MEM_Store;
          addr_d  = {bus.p_MEM_Address[WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          be_d    = lane_mask << off;
          wdata_d = (bus.p_MEM_StoreData & data_mask) << {off, 3'b000};
          size_d  = bus.p_MEM_Size;
          uns_d   = bus.p_MEM_Unsigned;
          off_d   = off;
        end
      end
      S_ACCESS: begin
        if (!bus.p_MEM_DataMemWait) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            ldata_d  = ld_ext;
            lvalid_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          ldata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge p_MEM_Clk or posedge p_MEM_Reset) begin
    if (p_MEM_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      aerr_q   <= aerr_d;
      berr_q   <= berr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
    end
  end

  assign bus.p_MEM_Stall         = accept || (state_q == S_ACCESS);
  assign bus.p_MEM_DataMemReq    = req_q;
  assign bus.p_MEM_DataMemWe     = we_q;
  assign bus.p_MEM_DataMemAddr   = addr_q;
  assign bus.p_MEM_DataMemByteEn = be_q;
  assign bus.p_MEM_DataMemWData  = wdata_q;
  assign bus.p_MEM_LoadData      = ldata_q;
  assign bus.p_MEM_LoadValid     = lvalid_q;
  assign bus.p_MEM_AlignErr      = aerr_q;
  assign bus.p_MEM_BusErr        = berr_q;
  assign bus.p_MEM_DbgState      = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (WIDTH=64, MAX_WAIT=4) with a byte-level
// transaction model producing per-cycle expectations.
module tb_mem_access_unit;
  localparam int W        = 64;
  localparam int MAX_WAIT = 4;

  logic clk, rst;
  mem_access_unit_if #(.WIDTH(W)) bus_if ();

  mem_access_unit #(.WIDTH(W), .MAX_WAIT(MAX_WAIT)) dut (
    .p_MEM_Clk   (clk),
    .p_MEM_Reset (rst),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          stall, req, lvalid, aerr, berr, chk_mem, we;
    logic [W-1:0]  ldata, addr, wdata;
    logic [7:0]    be;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_ld = '0;
  logic [W-1:0] snap_addr, snap_wdata;
  logic [7:0]   snap_be;
  logic         snap_we;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_illegal(logic ld, logic st, logic [1:0] sz, logic [W-1:0] a);
    int nb = 1 << sz;
    return (ld && st) || ((a % nb) != 0);
  endfunction

  function automatic logic [7:0] m_be(logic [1:0] sz, logic [W-1:0] a);
    logic [7:0] r = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < (1 << sz); i++) r[off + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] m_wdata(logic [1:0] sz, logic [W-1:0] a, logic [W-1:0] sd);
    logic [W-1:0] r = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < (1 << sz); i++) r[8*(off+i) +: 8] = sd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] m_load(logic [1:0] sz, logic uns, logic [W-1:0] a, logic [W-1:0] rd);
    logic [W-1:0] r = '0;
    int nb = 1 << sz;
    int off = int'(a[2:0]);
    for (int i = 0; i < nb; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.stall = 0; e.req = 0; e.lvalid = 0; e.aerr = 0; e.berr = 0;
    e.chk_mem = 0; e.we = 0; e.ldata = model_ld; e.addr = '0; e.wdata = '0; e.be = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus_if.p_MEM_DataMemReq) begin
      snap_addr  = bus_if.p_MEM_DataMemAddr;
      snap_wdata = bus_if.p_MEM_DataMemWData;
      snap_be    = bus_if.p_MEM_DataMemByteEn;
      snap_we    = bus_if.p_MEM_DataMemWe;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",  W'(bus_if.p_MEM_Stall),      W'(e.stall));
      chk("req",    W'(bus_if.p_MEM_DataMemReq), W'(e.req));
      chk("lvalid", W'(bus_if.p_MEM_LoadValid),  W'(e.lvalid));
      chk("aerr",   W'(bus_if.p_MEM_AlignErr),   W'(e.aerr));
      chk("berr",   W'(bus_if.p_MEM_BusErr),     W'(e.berr));
      chk("ldata",  bus_if.p_MEM_LoadData,       e.ldata);
      if (e.chk_mem) begin
        chk("we",    W'(bus_if.p_MEM_DataMemWe),     W'(e.we));
        chk("addr",  bus_if.p_MEM_DataMemAddr,       e.addr);
        chk("be",    W'(bus_if.p_MEM_DataMemByteEn), W'(e.be));
        chk("wdata", bus_if.p_MEM_DataMemWData,      e.wdata);
      end
    end
  end

  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [W-1:0] a, input logic [W-1:0] sd, input int waits,
                       input logic [W-1:0] rd, input logic drop_v);
    exp_t e;
    bit   abort;
    int   nacc;
    @(posedge clk); #1;
    bus_if.p_MEM_Valid = 1; bus_if.p_MEM_Load = ld; bus_if.p_MEM_Store = st;
    bus_if.p_MEM_Size = sz; bus_if.p_MEM_Unsigned = uns;
    bus_if.p_MEM_Address = a; bus_if.p_MEM_StoreData = sd;
    bus_if.p_MEM_DataMemWait = 0; bus_if.p_MEM_DataMemRData = {$urandom, $urandom};
    e = idle_exp(); e.stall = 1; exp_q.push_back(e);
    if (m_illegal(ld, st, sz, a)) begin
      @(posedge clk); #1;
      if (drop_v) bus_if.p_MEM_Valid = 0;
      e = idle_exp(); e.aerr = 1; exp_q.push_back(e);
    end else begin
      abort = (MAX_WAIT != 0) && (waits >= MAX_WAIT);
      nacc  = abort ? MAX_WAIT : waits + 1;
      for (int k = 1; k <= nacc; k++) begin
        @(posedge clk); #1;
        if (drop_v) bus_if.p_MEM_Valid = 0;
        bus_if.p_MEM_DataMemWait  = (k <= waits);
        bus_if.p_MEM_DataMemRData = (k <= waits) ? {$urandom, $urandom} : rd;
        e = idle_exp(); e.stall = 1; e.req = 1; e.chk_mem = 1; e.we = st;
        e.addr = a & ~64'h7; e.be = m_be(sz, a);
        e.wdata = st ? m_wdata(sz, a, sd) : '0;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus_if.p_MEM_DataMemWait = 0;
      if (abort) model_ld = '0;
      else if (ld) model_ld = m_load(sz, uns, a, rd);
      e = idle_exp(); e.berr = abort; e.lvalid = !abort && ld; exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus_if.p_MEM_Valid = 0;
    e = idle_exp(); exp_q.push_back(e);
  endtask

  initial begin
    rst = 1;
    bus_if.p_MEM_Valid = 0; bus_if.p_MEM_Load = 0; bus_if.p_MEM_Store = 0;
    bus_if.p_MEM_Size = 0; bus_if.p_MEM_Unsigned = 0; bus_if.p_MEM_Address = '0;
    bus_if.p_MEM_StoreData = '0; bus_if.p_MEM_DataMemWait = 0; bus_if.p_MEM_DataMemRData = '0;
    #12;
    chk("rst_req",    W'(bus_if.p_MEM_DataMemReq), '0);
    chk("rst_stall",  W'(bus_if.p_MEM_Stall), '0);
    chk("rst_addr",   bus_if.p_MEM_DataMemAddr, '0);
    chk("rst_be",     W'(bus_if.p_MEM_DataMemByteEn), '0);
    chk("rst_ldata",  bus_if.p_MEM_LoadData, '0);
    chk("rst_pulses", W'({bus_if.p_MEM_LoadValid, bus_if.p_MEM_AlignErr, bus_if.p_MEM_BusErr}), '0);
    chk("rst_state",  W'(bus_if.p_MEM_DbgState), '0);
    @(posedge clk); #2; rst = 0;

    do_op(0, 1, 2'd0, 0, 64'h1003, 64'h12AB, 0, '0, 0);
    chk("lit_sb_addr",  snap_addr, 64'h1000);
    chk("lit_sb_be",    W'(snap_be), 64'h08);
    chk("lit_sb_wdata", snap_wdata, 64'h00000000AB000000);
    chk("lit_sb_we",    W'(snap_we), 64'h1);
    do_op(1, 0, 2'd1, 0, 64'h2006, '0, 0, 64'h8001000000000000, 0);
    chk("lit_lh", bus_if.p_MEM_LoadData, 64'hFFFFFFFFFFFF8001);
    do_op(1, 0, 2'd1, 1, 64'h2006, '0, 0, 64'h8001000000000000, 0);
    chk("lit_lhu", bus_if.p_MEM_LoadData, 64'h0000000000008001);
    do_op(1, 0, 2'd2, 0, 64'h1002, '0, 0, '0, 0);
    do_op(1, 1, 2'd0, 0, 64'h1000, 64'h55, 0, '0, 0);
    do_op(1, 0, 2'd3, 0, 64'h3000, '0, 3, 64'h0123456789ABCDEF, 0);
    chk("lit_ld", bus_if.p_MEM_LoadData, 64'h0123456789ABCDEF);
    do_op(1, 0, 2'd2, 0, 64'h4000, '0, 10, 64'hFFFFFFFFFFFFFFFF, 0);
    chk("lit_timeout_ld", bus_if.p_MEM_LoadData, 64'h0);
    do_op(1, 0, 2'd0, 0, 64'h0005, '0, 1, 64'h0000_8000_0000_0000, 1);
    chk("lit_lb", bus_if.p_MEM_LoadData, 64'hFFFFFFFFFFFFFF80);
    do_op(0, 1, 2'd2, 0, 64'h0104, 64'hDEADBEEFCAFEF00D, 2, '0, 0);
    chk("lit_sw_wdata", snap_wdata, 64'hCAFEF00D00000000);
    do_op(0, 1, 2'd1, 0, 64'h010E, 64'h0000000000009876, 0, '0, 1);
    do_op(1, 0, 2'd2, 1, 64'h0008, '0, 0, 64'h89ABCDEF01234567, 0);
    do_op(1, 0, 2'd2, 0, 64'h000C, '0, 0, 64'h89ABCDEF01234567, 0);
    do_op(0, 1, 2'd1, 0, 64'h1001, 64'h1234, 0, '0, 0);
    do_op(1, 0, 2'd3, 0, 64'h0010, '0, MAX_WAIT - 1, 64'h7766554433221100, 0);

    // Reset in the middle of a waiting store, away from any clock edge.
    @(posedge clk); #1;
    bus_if.p_MEM_Valid = 1; bus_if.p_MEM_Store = 1; bus_if.p_MEM_Load = 0;
    bus_if.p_MEM_Size = 2'd3; bus_if.p_MEM_Address = 64'h40;
    bus_if.p_MEM_StoreData = 64'h1122334455667788; bus_if.p_MEM_DataMemWait = 1;
    @(posedge clk); #1;
    bus_if.p_MEM_Valid = 0;
    chk("pre_rst_req", W'(bus_if.p_MEM_DataMemReq), 64'h1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1; #1;
    chk("mid_rst_req",   W'(bus_if.p_MEM_DataMemReq), '0);
    chk("mid_rst_we",    W'(bus_if.p_MEM_DataMemWe), '0);
    chk("mid_rst_be",    W'(bus_if.p_MEM_DataMemByteEn), '0);
    chk("mid_rst_ldata", bus_if.p_MEM_LoadData, '0);
    model_ld = '0;
    @(posedge clk); #1;
    rst = 0; bus_if.p_MEM_DataMemWait = 0; bus_if.p_MEM_Store = 0;
    chk("post_rst_stall", W'(bus_if.p_MEM_Stall), '0);
    do_op(1, 0, 2'd3, 0, 64'h0048, '0, 3, 64'hA5A5_5A5A_0F0F_F0F0, 0);
    do_op(1, 0, 2'd0, 1, 64'h0007, '0, 0, 64'h8000_0000_0000_0000, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
